input_buffer_ctrl: RTL and testbench
====================================

// Module: input_buffer_ctrl
// PURPOSE
//  Controller/scheduler for the input buffer storage array. Owns write/read pointers, occupancy and
//  per-entry end-of-frame tags for up to IB_DEPTH buffered vectors, decides when the buffer fills and
//  when it drains to the filter stage, and reports overflow. Data never passes through this block;
//  it drives the storage array's write/read enables and addresses, and the downstream valid/eof.
// PARAMETERS
//  IB_DEPTH   4   number of vector slots in the storage array (power of two, >=2)
//  CNT_W      8   width of the dropped-vector counter
// PORTS
//  clk             in   1                   single clock, rising edge
//  reset           in   1                   synchronous, active-high
//  enable          in   1                   tracing enable; 0 forces return to IDLE once drained
//  cfg_threshold   in   $clog2(IB_DEPTH)+1  occupancy that triggers a drain
//  in_valid        in   1                   upstream vector present this cycle
//  in_eof          in   1                   upstream vector is last of frame
//  out_ready       in   1                   filter stage can accept a vector
//  wr_en           out  1                   write strobe to storage array
//  wr_addr         out  $clog2(IB_DEPTH)    write slot
//  rd_en           out  1                   read strobe to storage array (1-cycle read latency)
//  rd_addr         out  $clog2(IB_DEPTH)    read slot
//  out_valid       out  1                   storage read data valid this cycle (rd_en delayed 1)
//  out_eof         out  1                   eof tag of the vector qualified by out_valid
//  occupancy       out  $clog2(IB_DEPTH)+1  vectors currently held
//  full / empty    out  1                   occupancy==IB_DEPTH / occupancy==0
//  overflow        out  1                   sticky: a vector was dropped since reset
//  dropped         out  CNT_W               dropped-vector count, saturates at all-ones
// BEHAVIOUR
//  - Reset: state=IDLE; pointers, occupancy, dropped, eof tags = 0; overflow=0; all strobes and
//    out_valid/out_eof = 0; empty=1, full=0. Reset mid-drain discards contents; no out_valid after.
//  - Effective threshold T = clamp(cfg_threshold, 1, IB_DEPTH), sampled every cycle.
//  - States: IDLE, FILL, DRAIN.
//    IDLE : no writes, no reads. enable=1 -> FILL next cycle.
//    FILL : writes accepted, rd_en=0. -> DRAIN when post-update occupancy>=T, or an accepted write
//           carries in_eof. enable=0 with occupancy>0 -> DRAIN; with occupancy==0 -> IDLE.
//    DRAIN: rd_en = out_ready & ~empty; writes still accepted. When post-update occupancy==0:
//           -> FILL if enable, else IDLE.
//  - Write accept: wr_en = in_valid & (state!=IDLE) & (~full | rd_en). Full with simultaneous
//    read accepts the write (occupancy unchanged). Full without read drops the vector: overflow<=1,
//    dropped += 1 (saturating). in_valid in IDLE is ignored, not counted as dropped.
//  - Same-cycle accepted write and read: occupancy unchanged, both pointers advance.
//  - Pointers wrap modulo IB_DEPTH. eof tag written at wr_addr with wr_en; read at rd_addr with
//    rd_en and presented as out_eof one cycle later alongside out_valid.
//  - wr_addr/rd_addr always show current pointer values; strobes are combinational from state/inputs.
//  - Latency: vector written in cycle t is earliest readable at t+1 (rd_en), out_valid at t+2.
//  - Reads are never issued when empty; out_valid never asserts without a prior rd_en.
// TESTING (IB_DEPTH=4)
//  1 T=2, enable=1, two in_valid vectors back-to-back, out_ready=1 -> FILL->DRAIN after 2nd write;
//    rd_en two cycles at addr 0,1; out_valid two cycles; return to FILL, empty=1.
//  2 T=4, write 1 vector with in_eof=1 -> immediate DRAIN; one out_valid with out_eof=1.
//  3 T=4, out_ready=0, six vectors -> occupancy=4, full=1, overflow=1, dropped=2; out_ready=1 ->
//    four reads addr 0..3 in order, then empty.
//  4 Full, out_ready=1, in_valid held every cycle -> one write+one read per cycle, occupancy stays 4,
//    pointers wrap 3->0, dropped unchanged.
//  5 DRAIN with occupancy=3, assert reset one cycle -> next cycle IDLE, occupancy=0, no out_valid,
//    overflow=0, dropped=0.
//  6 cfg_threshold=0 and =7 -> behave as T=1 and T=4; enable=0 mid-FILL with 1 held -> drains, IDLE.

Source files
------------

// File: rtl/input_buffer_ctrl.sv
// input_buffer_ctrl
// Scheduler for the input buffer storage array. It tracks the write and read
// pointers, the occupancy and one end-of-frame tag per slot. It decides when
// the buffer fills and when it drains toward the filter stage, and it counts
// vectors dropped on overflow. Vector data never passes through this block;
// only the storage strobes, addresses and downstream valid/eof come from here.
module input_buffer_ctrl #(
    parameter int IB_DEPTH = 4,
    parameter int CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [$clog2(IB_DEPTH):0]   cfg_threshold,
    input  logic                        in_valid,
    input  logic                        in_eof,
    input  logic                        out_ready,
    output logic                        wr_en,
    output logic [$clog2(IB_DEPTH)-1:0] wr_addr,
    output logic                        rd_en,
    output logic [$clog2(IB_DEPTH)-1:0] rd_addr,
    output logic                        out_valid,
    output logic                        out_eof,
    output logic [$clog2(IB_DEPTH):0]   occupancy,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow,
    output logic [CNT_W-1:0]            dropped
);

    localparam int AW = $clog2(IB_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_OCC = OW'(IB_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]       occ_q, occ_d;
    logic [IB_DEPTH-1:0] eof_tag_q, eof_tag_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    dropped_q, dropped_d;
    logic                out_valid_q, out_valid_d;
    logic                out_eof_q, out_eof_d;

    logic [OW-1:0]       thr_eff;
    logic                active;
    logic                drop;

    assign full      = (occ_q == DEPTH_OCC);
    assign empty     = (occ_q == '0);
    assign wr_addr   = wr_ptr_q;
    assign rd_addr   = rd_ptr_q;
    assign occupancy = occ_q;
    assign overflow  = overflow_q;
    assign dropped   = dropped_q;
    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;

    // Clamp the configured threshold into 1..IB_DEPTH so a drain is always reachable
    always_comb begin
        thr_eff = cfg_threshold;
        if (cfg_threshold == '0) begin
            thr_eff = OW'(1);
        end else if (cfg_threshold > DEPTH_OCC) begin
            thr_eff = DEPTH_OCC;
        end
    end

    // Storage strobes; a read frees a slot in the same cycle so a full buffer can still take a write
    always_comb begin
        active = (state_q != ST_IDLE) && !reset;
        rd_en  = active && (state_q == ST_DRAIN) && out_ready && !empty;
        wr_en  = active && in_valid && (!full || rd_en);
        drop   = active && in_valid && full && !rd_en;
    end

    // Next-state computation for pointers, occupancy, tags, drop accounting and the FSM
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        eof_tag_d   = eof_tag_q;
        overflow_d  = overflow_q;
        dropped_d   = dropped_q;
        out_valid_d = rd_en;
        out_eof_d   = rd_en && eof_tag_q[rd_ptr_q];

        if (wr_en) begin
            wr_ptr_d            = wr_ptr_q + AW'(1);
            eof_tag_d[wr_ptr_q] = in_eof;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (dropped_q != '1) begin
                dropped_d = dropped_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if ((occ_d >= thr_eff) || (wr_en && in_eof)) begin
                    state_d = ST_DRAIN;
                end else if (!enable) begin
                    state_d = (occ_d != '0) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (occ_d == '0) begin
                    state_d = enable ? ST_FILL : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register all state; reset discards any buffered contents and pending read data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            eof_tag_q   <= '0;
            overflow_q  <= 1'b0;
            dropped_q   <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            eof_tag_q   <= eof_tag_d;
            overflow_q  <= overflow_d;
            dropped_q   <= dropped_d;
            out_valid_q <= out_valid_d;
            out_eof_q   <= out_eof_d;
        end
    end

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// tb_input_buffer_ctrl
// Cycle-by-cycle vector table for input_buffer_ctrl with IB_DEPTH=4, plus an
// eof-tag queue that follows accepted writes through to out_valid/out_eof.
module tb_input_buffer_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] cfg_threshold;
    logic       in_valid;
    logic       in_eof;
    logic       out_ready;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic       out_valid;
    logic       out_eof;
    logic [2:0] occupancy;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] dropped;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] thr;
        logic       iv;
        logic       ieof;
        logic       ordy;
        logic       x_wr;
        logic [1:0] x_wa;
        logic       x_rd;
        logic [1:0] x_ra;
        logic       x_ov;
        logic       x_oe;
        logic [2:0] x_occ;
        logic       x_ovf;
        logic [7:0] x_drp;
    } vec_t;

    vec_t vecs[$];
    logic sb[$];

    input_buffer_ctrl #(
        .IB_DEPTH(4),
        .CNT_W   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cfg_threshold(cfg_threshold),
        .in_valid     (in_valid),
        .in_eof       (in_eof),
        .out_ready    (out_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .out_valid    (out_valid),
        .out_eof      (out_eof),
        .occupancy    (occupancy),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .dropped      (dropped)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last-resort guard so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void add(input int r, input int e, input int t, input int iv,
                                input int ie, input int ordy, input int w, input int wa,
                                input int rd, input int ra, input int ov, input int oe,
                                input int oc, input int of, input int dp);
        vec_t v;
        v.rst   = r[0];
        v.en    = e[0];
        v.thr   = t[2:0];
        v.iv    = iv[0];
        v.ieof  = ie[0];
        v.ordy  = ordy[0];
        v.x_wr  = w[0];
        v.x_wa  = wa[1:0];
        v.x_rd  = rd[0];
        v.x_ra  = ra[1:0];
        v.x_ov  = ov[0];
        v.x_oe  = oe[0];
        v.x_occ = oc[2:0];
        v.x_ovf = of[0];
        v.x_drp = dp[7:0];
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pop the oldest accepted eof tag whenever read data is presented
    task automatic sbCheck(input string tag);
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL %s sb_underflow: got out_valid=1 expected no pending vector", tag);
            end else begin
                cmp({tag, " sb_eof"}, {31'd0, out_eof}, {31'd0, sb.pop_front()});
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset         = v.rst;
        enable        = v.en;
        cfg_threshold = v.thr;
        in_valid      = v.iv;
        in_eof        = v.ieof;
        out_ready     = v.ordy;
        if (v.rst) begin
            sb.delete();
        end else if (v.x_wr) begin
            sb.push_back(v.ieof);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string p;
        p = $sformatf("row%0d", idx);
        cmp({p, " wr_en"},     {31'd0, wr_en},     {31'd0, v.x_wr});
        cmp({p, " wr_addr"},   {30'd0, wr_addr},   {30'd0, v.x_wa});
        cmp({p, " rd_en"},     {31'd0, rd_en},     {31'd0, v.x_rd});
        cmp({p, " rd_addr"},   {30'd0, rd_addr},   {30'd0, v.x_ra});
        cmp({p, " out_valid"}, {31'd0, out_valid}, {31'd0, v.x_ov});
        cmp({p, " out_eof"},   {31'd0, out_eof},   {31'd0, v.x_oe});
        cmp({p, " occupancy"}, {29'd0, occupancy}, {29'd0, v.x_occ});
        cmp({p, " full"},      {31'd0, full},      {31'd0, (v.x_occ == 3'd4)});
        cmp({p, " empty"},     {31'd0, empty},     {31'd0, (v.x_occ == 3'd0)});
        cmp({p, " overflow"},  {31'd0, overflow},  {31'd0, v.x_ovf});
        cmp({p, " dropped"},   {24'd0, dropped},   {24'd0, v.x_drp});
        sbCheck(p);
    endtask

    initial begin
        int reads;
        reset         = 1'b1;
        enable        = 1'b0;
        cfg_threshold = 3'd0;
        in_valid      = 1'b0;
        in_eof        = 1'b0;
        out_ready     = 1'b0;

        //  rst en thr iv ie rdy | wr wa rd ra ov oe occ ovf drp
        // T=2: two writes, drain addr 0,1, back to FILL
        add(0,1,2, 0,0,1, 0,0,0,0,0,0,0,0,0);
        add(0,1,2, 1,0,1, 1,0,0,0,0,0,0,0,0);
        add(0,1,2, 1,0,1, 1,1,0,0,0,0,1,0,0);
        add(0,1,2, 0,0,1, 0,2,1,0,0,0,2,0,0);
        add(0,1,2, 0,0,1, 0,2,1,1,1,0,1,0,0);
        add(0,1,2, 0,0,1, 0,2,0,2,1,0,0,0,0);
        add(0,1,2, 0,0,1, 0,2,0,2,0,0,0,0,0);
        // T=4: a single eof vector drains immediately
        add(0,1,4, 1,1,1, 1,2,0,2,0,0,0,0,0);
        add(0,1,4, 0,0,1, 0,3,1,2,0,0,1,0,0);
        add(0,1,4, 0,0,1, 0,3,0,3,1,1,0,0,0);
        add(0,1,4, 0,0,1, 0,3,0,3,0,0,0,0,0);
        // reset to realign pointers at slot 0
        add(1,0,4, 0,0,0, 0,3,0,3,0,0,0,0,0);
        add(0,1,4, 0,0,0, 0,0,0,0,0,0,0,0,0);
        // six vectors with out_ready low: two dropped, then four reads 0..3
        add(0,1,4, 1,0,0, 1,0,0,0,0,0,0,0,0);
        add(0,1,4, 1,0,0, 1,1,0,0,0,0,1,0,0);
        add(0,1,4, 1,0,0, 1,2,0,0,0,0,2,0,0);
        add(0,1,4, 1,0,0, 1,3,0,0,0,0,3,0,0);
        add(0,1,4, 1,0,0, 0,0,0,0,0,0,4,0,0);
        add(0,1,4, 1,0,0, 0,0,0,0,0,0,4,1,1);
        add(0,1,4, 0,0,1, 0,0,1,0,0,0,4,1,2);
        add(0,1,4, 0,0,1, 0,0,1,1,1,0,3,1,2);
        add(0,1,4, 0,0,1, 0,0,1,2,1,0,2,1,2);
        add(0,1,4, 0,0,1, 0,0,1,3,1,0,1,1,2);
        add(0,1,4, 0,0,1, 0,0,0,0,1,0,0,1,2);
        // full buffer streaming one write and one read per cycle, pointers wrap
        add(0,1,4, 1,0,0, 1,0,0,0,0,0,0,1,2);
        add(0,1,4, 1,0,0, 1,1,0,0,0,0,1,1,2);
        add(0,1,4, 1,0,0, 1,2,0,0,0,0,2,1,2);
        add(0,1,4, 1,0,0, 1,3,0,0,0,0,3,1,2);
        add(0,1,4, 1,1,1, 1,0,1,0,0,0,4,1,2);
        add(0,1,4, 1,0,1, 1,1,1,1,1,0,4,1,2);
        add(0,1,4, 1,1,1, 1,2,1,2,1,0,4,1,2);
        add(0,1,4, 1,0,1, 1,3,1,3,1,0,4,1,2);
        add(0,1,4, 1,1,1, 1,0,1,0,1,0,4,1,2);
        add(0,1,4, 1,0,1, 1,1,1,1,1,1,4,1,2);
        add(0,1,4, 0,0,1, 0,2,1,2,1,0,4,1,2);
        add(0,1,4, 0,0,1, 0,2,1,3,1,1,3,1,2);
        add(0,1,4, 0,0,1, 0,2,1,0,1,0,2,1,2);
        add(0,1,4, 0,0,1, 0,2,1,1,1,1,1,1,2);
        add(0,1,4, 0,0,1, 0,2,0,2,1,0,0,1,2);
        // reset while draining three vectors
        add(0,1,3, 1,0,0, 1,2,0,2,0,0,0,1,2);
        add(0,1,3, 1,0,0, 1,3,0,2,0,0,1,1,2);
        add(0,1,3, 1,0,0, 1,0,0,2,0,0,2,1,2);
        add(0,1,3, 0,0,0, 0,1,0,2,0,0,3,1,2);
        add(1,1,3, 0,0,0, 0,1,0,2,0,0,3,1,2);
        add(0,0,3, 1,0,1, 0,0,0,0,0,0,0,0,0);
        add(0,0,3, 1,0,1, 0,0,0,0,0,0,0,0,0);
        // threshold 0 acts as 1
        add(0,1,0, 0,0,0, 0,0,0,0,0,0,0,0,0);
        add(0,1,0, 1,0,0, 1,0,0,0,0,0,0,0,0);
        add(0,1,0, 0,0,1, 0,1,1,0,0,0,1,0,0);
        // threshold 7 acts as 4
        add(0,1,7, 0,0,1, 0,1,0,1,1,0,0,0,0);
        add(0,1,7, 1,0,1, 1,1,0,1,0,0,0,0,0);
        add(0,1,7, 1,0,1, 1,2,0,1,0,0,1,0,0);
        add(0,1,7, 1,0,1, 1,3,0,1,0,0,2,0,0);
        add(0,1,7, 1,0,1, 1,0,0,1,0,0,3,0,0);
        add(0,1,7, 0,0,1, 0,1,1,1,0,0,4,0,0);
        add(0,1,7, 0,0,1, 0,1,1,2,1,0,3,0,0);
        add(0,1,7, 0,0,1, 0,1,1,3,1,0,2,0,0);
        add(0,1,7, 0,0,1, 0,1,1,0,1,0,1,0,0);
        add(0,1,7, 0,0,1, 0,1,0,1,1,0,0,0,0);
        // enable drops with one vector held: drain it, then IDLE ignores in_valid
        add(0,1,4, 1,0,0, 1,1,0,1,0,0,0,0,0);
        add(0,0,4, 0,0,0, 0,2,0,1,0,0,1,0,0);
        add(0,0,4, 0,0,1, 0,2,1,1,0,0,1,0,0);
        add(0,0,4, 1,0,1, 0,2,0,2,1,0,0,0,0);
        add(0,0,4, 1,0,1, 0,2,0,2,0,0,0,0,0);

        repeat (3) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
        end
        cmp("table sb_drained", sb.size(), 32'd0);

        // dropped counter saturates at all-ones under a long overflow
        @(negedge clk);
        reset     = 1'b1;
        enable    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        reset         = 1'b0;
        enable        = 1'b1;
        cfg_threshold = 3'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_eof   = (i == 3);
            sb.push_back(i == 3);
        end
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_eof   = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        cmp("sat dropped",   {24'd0, dropped},   32'hFF);
        cmp("sat overflow",  {31'd0, overflow},  32'd1);
        cmp("sat occupancy", {29'd0, occupancy}, 32'd4);
        cmp("sat full",      {31'd0, full},      32'd1);
        out_ready = 1'b1;
        reads     = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1) reads++;
            sbCheck($sformatf("sat_drain%0d", c));
        end
        cmp("sat drain_reads", reads, 32'd4);
        cmp("sat empty",       {31'd0, empty}, 32'd1);
        cmp("sat sb_drained",  sb.size(), 32'd0);
        cmp("sat dropped_held", {24'd0, dropped}, 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
